// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer.
package rv_pkg;

    // Major opcodes (IR[6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2,
        PC_TRAP  = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_BUS_ERR = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } trap_cause_e;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_TRAP    = 3'd5
    } state_e;

    // Register/immediate arithmetic: alt selects SUB (OP only) or SRA.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch compares: EQ/NE use the subtract-zero path, signed and
    // unsigned magnitude compares use the set-less-than paths.
    function automatic alu_op_e alu_from_branch(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3[2:1])
            2'b10:   op = ALU_SLT;
            2'b11:   op = ALU_SLTU;
            default: op = ALU_SUB;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_control_fsm_legal_check.sv
// Combinational legality decode of an RV32I instruction word's
// opcode/funct3/funct7 fields.
module rv_legal_check
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       legal
);

    // Classify the encoding; anything not listed (incl. SYSTEM) is illegal.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE: begin
                legal = 1'b1;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                legal = (funct3 <= 3'b010);
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001) begin
                    legal = (funct7 == FUNCT7_BASE);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                end else begin
                    legal = 1'b1;
                end
            end
            OPC_OP: begin
                if (funct7 == FUNCT7_BASE) begin
                    legal = 1'b1;
                end else if (funct7 == FUNCT7_ALT) begin
                    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                end else begin
                    legal = 1'b0;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXECUTE [-> MEM],
// with illegal-instruction, bus-error and bus-timeout traps.
module rv_control_fsm
    import rv_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       branch_taken,
    input  logic       bus_ack,
    input  logic       bus_err,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] imm_sel,
    output logic [3:0] alu_op,
    output logic       bus_req,
    output logic       bus_we,
    output logic       bus_addr_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       instret
);

    localparam int CNT_W = 16;
    // The counter holds the number of already-elapsed wait cycles, so the
    // BUS_TIMEOUT-th cycle of an unanswered request is the last one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    state_e            state_reg;
    state_e            state_next;
    trap_cause_e       cause_reg;
    trap_cause_e       cause_next;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              legal;
    logic              bus_state;
    logic              timeout;
    logic              is_load;
    logic              is_store;

    rv_legal_check u_legal (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .legal  (legal)
    );

    assign bus_state  = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign timeout    = bus_state && !bus_ack && !bus_err && (wait_cnt_reg == CNT_LAST);
    assign is_load    = (opcode == OPC_LOAD);
    assign is_store   = (opcode == OPC_STORE);
    assign trap_cause = cause_reg;

    // State register; reset forces RESET asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus wait counter: restarts whenever a bus state is entered or left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (bus_state && (state_next == state_reg)) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    // Trap cause is captured on trap entry and held until the next trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_reg <= CAUSE_NONE;
        end else begin
            cause_reg <= cause_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next   = state_reg;
        cause_next   = cause_reg;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        imm_sel      = IMM_I;
        alu_op       = ALU_ADD;
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr_sel = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        trap         = 1'b0;
        instret      = 1'b0;

        case (state_reg)
            ST_RESET: begin
                state_next = ST_FETCH;
            end

            ST_FETCH: begin
                bus_req = 1'b1;
                if (bus_err) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_BUS_ERR;
                end else if (bus_ack) begin
                    ir_we      = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end

            ST_DECODE: begin
                // Register file is read this cycle; only legality steers.
                if (legal) begin
                    state_next = ST_EXECUTE;
                end else begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end

            ST_EXECUTE: begin
                state_next = ST_FETCH;
                case (opcode)
                    OPC_OP: begin
                        alu_op  = alu_from_funct(funct3, funct7[5]);
                        rf_we   = 1'b1;
                        pc_we   = 1'b1;
                        instret = 1'b1;
                    end
                    OPC_OP_IMM: begin
                        // funct7[5] only means SRA for the right shift; for
                        // funct3 000 those bits belong to the immediate.
                        alu_op    = alu_from_funct(funct3, (funct3 == 3'b101) && funct7[5]);
                        alu_b_sel = 1'b1;
                        imm_sel   = IMM_I;
                        rf_we     = 1'b1;
                        pc_we     = 1'b1;
                        instret   = 1'b1;
                    end
                    OPC_LUI: begin
                        imm_sel = IMM_U;
                        wb_sel  = WB_IMM;
                        rf_we   = 1'b1;
                        pc_we   = 1'b1;
                        instret = 1'b1;
                    end
                    OPC_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        imm_sel   = IMM_U;
                        rf_we     = 1'b1;
                        pc_we     = 1'b1;
                        instret   = 1'b1;
                    end
                    OPC_JAL: begin
                        imm_sel = IMM_J;
                        wb_sel  = WB_PC4;
                        pc_sel  = PC_IMM;
                        rf_we   = 1'b1;
                        pc_we   = 1'b1;
                        instret = 1'b1;
                    end
                    OPC_JALR: begin
                        alu_b_sel = 1'b1;
                        imm_sel   = IMM_I;
                        alu_op    = ALU_ADD;
                        wb_sel    = WB_PC4;
                        pc_sel    = PC_ALU;
                        rf_we     = 1'b1;
                        pc_we     = 1'b1;
                        instret   = 1'b1;
                    end
                    OPC_BRANCH: begin
                        imm_sel = IMM_B;
                        alu_op  = alu_from_branch(funct3);
                        pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
                        pc_we   = 1'b1;
                        instret = 1'b1;
                    end
                    OPC_FENCE: begin
                        pc_we   = 1'b1;
                        instret = 1'b1;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel  = 1'b1;
                        imm_sel    = is_store ? IMM_S : IMM_I;
                        alu_op     = ALU_ADD;
                        state_next = ST_MEM;
                    end
                    default: begin
                        // Unreachable behind the legality check; trap rather
                        // than retire if the IR ever changes underneath us.
                        state_next = ST_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end

            ST_MEM: begin
                // Keep the address computation stable for the whole access.
                bus_req      = 1'b1;
                bus_addr_sel = 1'b1;
                bus_we       = is_store;
                alu_b_sel    = 1'b1;
                imm_sel      = is_store ? IMM_S : IMM_I;
                alu_op       = ALU_ADD;
                if (bus_err) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_BUS_ERR;
                end else if (bus_ack) begin
                    rf_we      = is_load;
                    wb_sel     = is_load ? WB_MEM : WB_ALU;
                    pc_we      = 1'b1;
                    instret    = 1'b1;
                    state_next = ST_FETCH;
                end else if (timeout) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end

            ST_TRAP: begin
                pc_we      = 1'b1;
                pc_sel     = PC_TRAP;
                trap       = 1'b1;
                state_next = ST_FETCH;
            end

            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_control_fsm.sv
// Directed, table-driven bench for rv_control_fsm (BUS_TIMEOUT = 4).
module tb_rv_control_fsm;
    import rv_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       branch_taken;
    logic       bus_ack;
    logic       bus_err;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [2:0] imm_sel;
    logic [3:0] alu_op;
    logic       bus_req;
    logic       bus_we;
    logic       bus_addr_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       trap;
    logic [1:0] trap_cause;
    logic       instret;

    int n_vec;
    int n_bad;
    logic [1:0] exp_cause;

    rv_control_fsm #(.BUS_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .branch_taken (branch_taken),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .imm_sel      (imm_sel),
        .alu_op       (alu_op),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr_sel (bus_addr_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bt;
        int         waits;
        logic       noise;
        logic [20:0] exp;
        logic       is_trap;
    } vec_t;

    vec_t tbl[$];

    // Expected output word for an EXECUTE/TRAP cycle (no bus activity, no ir_we).
    function automatic logic [20:0] ex(input logic pw, input logic [1:0] ps, input logic a,
                                       input logic b, input logic [2:0] imm, input logic [3:0] alu,
                                       input logic rw, input logic [1:0] wb, input logic tr,
                                       input logic ir);
        return {1'b0, pw, ps, a, b, imm, alu, 3'b000, rw, wb, tr, ir};
    endfunction

    function automatic logic [20:0] obs();
        return {ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, imm_sel, alu_op,
                bus_req, bus_we, bus_addr_sel, rf_we, wb_sel, trap, instret};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic add_vec(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic bt, input int waits,
                           input logic noise, input logic [20:0] exp, input logic is_trap);
        vec_t v;
        v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.bt = bt;
        v.waits = waits; v.noise = noise; v.exp = exp; v.is_trap = is_trap;
        tbl.push_back(v);
    endtask

    // Fetch with 'waits' unanswered cycles, ack, then one DECODE cycle.
    task automatic fetch(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input int waits, input logic noise);
        opcode = op; funct3 = f3; funct7 = f7;
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            bus_ack = 1'b0; bus_err = 1'b0;
            #1;
            check({nm, "_fetch_wait"}, 32'({bus_req, bus_addr_sel, bus_we, ir_we}), 32'b1000);
        end
        @(negedge clk);
        bus_ack = 1'b1; bus_err = 1'b0;
        #1;
        check({nm, "_fetch_ack"}, 32'({bus_req, bus_addr_sel, bus_we, ir_we}), 32'b1001);
        @(negedge clk);
        bus_ack = noise; bus_err = noise;
        #1;
        check({nm, "_decode"}, 32'(obs()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        fetch(v.name, v.op, v.f3, v.f7, v.waits, v.noise);
        @(negedge clk);
        bus_ack = 1'b0; bus_err = 1'b0; branch_taken = v.bt;
        #1;
        $display("vec %-10s op=%b f3=%b f7=%h bt=%0d -> %h (exp %h)",
                 v.name, v.op, v.f3, v.f7, v.bt, obs(), v.exp);
        check({v.name, "_exec"}, 32'(obs()), 32'(v.exp));
        if (v.is_trap) exp_cause = 2'd1;
        check({v.name, "_cause"}, 32'(trap_cause), 32'(exp_cause));
        branch_taken = 1'b0;
    endtask

    // Load or store through MEM with 'waits' unanswered cycles.
    task automatic mem_access(input string nm, input logic [2:0] f3, input logic st, input int waits);
        vec_t v;
        v.name = nm; v.op = st ? OPC_STORE : OPC_LOAD; v.f3 = f3; v.f7 = 7'h00;
        v.bt = 1'b0; v.waits = 1; v.noise = 1'b0; v.is_trap = 1'b0;
        v.exp = ex(1'b0, 2'd0, 1'b0, 1'b1, st ? IMM_S : IMM_I, ALU_ADD, 1'b0, 2'd0, 1'b0, 1'b0);
        run_vec(v);
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            bus_ack = 1'b0; bus_err = 1'b0;
            #1;
            check({nm, "_mem_wait"},
                  32'({bus_req, bus_addr_sel, bus_we, rf_we, pc_we, instret}),
                  32'({1'b1, 1'b1, st, 1'b0, 1'b0, 1'b0}));
        end
        @(negedge clk);
        bus_ack = 1'b1;
        #1;
        $display("mem %-10s ack: rf_we=%0d wb_sel=%0d bus_we=%0d instret=%0d",
                 nm, rf_we, wb_sel, bus_we, instret);
        check({nm, "_mem_ack"},
              32'({bus_req, bus_addr_sel, bus_we, rf_we, wb_sel, pc_we, pc_sel, instret}),
              32'({1'b1, 1'b1, st, ~st, st ? 2'd0 : 2'd1, 1'b1, 2'd0, 1'b1}));
    endtask

    localparam logic [20:0] TRAP_EXP = {1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 3'd0, 4'd0, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_bad = 0; exp_cause = 2'd0;
        rst_n = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        branch_taken = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;

        // --- Reset behaviour ---
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 32'(obs()), 32'd0);
        check("reset_cause", 32'(trap_cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_state_cycle", 32'(obs()), 32'd0);
        @(negedge clk);
        #1;
        check("fetch_after_reset", 32'(bus_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_drops_req", 32'(obs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_cycle_again", 32'(bus_req), 32'd0);
        $display("reset sequence done");

        // --- Table of single-instruction vectors ---
        add_vec("addi",   OPC_OP_IMM, 3'b000, 7'h00, 1'b0, 3, 1'b0, ex(1, 2'd0, 0, 1, IMM_I, ALU_ADD, 1, 2'd0, 0, 1), 0);
        add_vec("add",    OPC_OP,     3'b000, 7'h00, 1'b0, 0, 1'b1, ex(1, 2'd0, 0, 0, IMM_I, ALU_ADD, 1, 2'd0, 0, 1), 0);
        add_vec("sub",    OPC_OP,     3'b000, 7'h20, 1'b0, 1, 1'b0, ex(1, 2'd0, 0, 0, IMM_I, ALU_SUB, 1, 2'd0, 0, 1), 0);
        add_vec("sra",    OPC_OP,     3'b101, 7'h20, 1'b0, 0, 1'b0, ex(1, 2'd0, 0, 0, IMM_I, ALU_SRA, 1, 2'd0, 0, 1), 0);
        add_vec("srai",   OPC_OP_IMM, 3'b101, 7'h20, 1'b0, 0, 1'b0, ex(1, 2'd0, 0, 1, IMM_I, ALU_SRA, 1, 2'd0, 0, 1), 0);
        add_vec("sltiu",  OPC_OP_IMM, 3'b011, 7'h7f, 1'b0, 2, 1'b0, ex(1, 2'd0, 0, 1, IMM_I, ALU_SLTU, 1, 2'd0, 0, 1), 0);
        add_vec("addi_n", OPC_OP_IMM, 3'b000, 7'h7f, 1'b0, 0, 1'b0, ex(1, 2'd0, 0, 1, IMM_I, ALU_ADD, 1, 2'd0, 0, 1), 0);
        add_vec("lui",    OPC_LUI,    3'b101, 7'h12, 1'b0, 0, 1'b0, ex(1, 2'd0, 0, 0, IMM_U, ALU_ADD, 1, 2'd3, 0, 1), 0);
        add_vec("auipc",  OPC_AUIPC,  3'b000, 7'h00, 1'b0, 0, 1'b0, ex(1, 2'd0, 1, 1, IMM_U, ALU_ADD, 1, 2'd0, 0, 1), 0);
        add_vec("jal",    OPC_JAL,    3'b000, 7'h00, 1'b0, 0, 1'b0, ex(1, 2'd1, 0, 0, IMM_J, ALU_ADD, 1, 2'd2, 0, 1), 0);
        add_vec("jalr",   OPC_JALR,   3'b000, 7'h00, 1'b0, 0, 1'b0, ex(1, 2'd2, 0, 1, IMM_I, ALU_ADD, 1, 2'd2, 0, 1), 0);
        add_vec("beq_t",  OPC_BRANCH, 3'b000, 7'h00, 1'b1, 0, 1'b0, ex(1, 2'd1, 0, 0, IMM_B, ALU_SUB, 0, 2'd0, 0, 1), 0);
        add_vec("beq_nt", OPC_BRANCH, 3'b000, 7'h00, 1'b0, 0, 1'b0, ex(1, 2'd0, 0, 0, IMM_B, ALU_SUB, 0, 2'd0, 0, 1), 0);
        add_vec("bltu_t", OPC_BRANCH, 3'b110, 7'h00, 1'b1, 0, 1'b0, ex(1, 2'd1, 0, 0, IMM_B, ALU_SLTU, 0, 2'd0, 0, 1), 0);
        add_vec("bge_nt", OPC_BRANCH, 3'b101, 7'h00, 1'b0, 0, 1'b0, ex(1, 2'd0, 0, 0, IMM_B, ALU_SLT, 0, 2'd0, 0, 1), 0);
        add_vec("fence",  OPC_FENCE,  3'b000, 7'h00, 1'b0, 0, 1'b0, ex(1, 2'd0, 0, 0, IMM_I, ALU_ADD, 0, 2'd0, 0, 1), 0);
        add_vec("op_f7",  OPC_OP,     3'b000, 7'h01, 1'b0, 0, 1'b0, TRAP_EXP, 1);
        add_vec("op_alt", OPC_OP,     3'b111, 7'h20, 1'b0, 0, 1'b0, TRAP_EXP, 1);
        add_vec("system", OPC_SYSTEM, 3'b000, 7'h00, 1'b0, 0, 1'b0, TRAP_EXP, 1);
        add_vec("br_010", OPC_BRANCH, 3'b010, 7'h00, 1'b1, 0, 1'b0, TRAP_EXP, 1);
        add_vec("slli_b", OPC_OP_IMM, 3'b001, 7'h20, 1'b0, 0, 1'b0, TRAP_EXP, 1);
        add_vec("srli_b", OPC_OP_IMM, 3'b101, 7'h01, 1'b0, 0, 1'b0, TRAP_EXP, 1);
        add_vec("jalr_b", OPC_JALR,   3'b001, 7'h00, 1'b0, 0, 1'b0, TRAP_EXP, 1);
        add_vec("ld_011", OPC_LOAD,   3'b011, 7'h00, 1'b0, 0, 1'b0, TRAP_EXP, 1);
        add_vec("st_011", OPC_STORE,  3'b011, 7'h00, 1'b0, 0, 1'b0, TRAP_EXP, 1);
        add_vec("opc_0",  7'b0000000, 3'b000, 7'h00, 1'b0, 0, 1'b0, TRAP_EXP, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        // --- LW then SW, each MEM acked after 2 wait cycles ---
        mem_access("lw", 3'b010, 1'b0, 2);
        mem_access("sw", 3'b010, 1'b1, 2);

        // --- bus_err together with bus_ack in MEM ---
        begin
            vec_t v;
            v.name = "lw_err"; v.op = OPC_LOAD; v.f3 = 3'b010; v.f7 = 7'h00; v.bt = 1'b0;
            v.waits = 0; v.noise = 1'b0; v.is_trap = 1'b0;
            v.exp = ex(0, 2'd0, 0, 1, IMM_I, ALU_ADD, 0, 2'd0, 0, 0);
            run_vec(v);
        end
        @(negedge clk);
        bus_ack = 1'b1; bus_err = 1'b1;
        #1;
        check("mem_err_no_retire", 32'({rf_we, pc_we, instret, bus_req}), 32'b0001);
        @(negedge clk);
        bus_ack = 1'b0; bus_err = 1'b0;
        #1;
        exp_cause = 2'd2;
        $display("trap bus_err: trap=%0d cause=%0d pc_sel=%0d", trap, trap_cause, pc_sel);
        check("mem_err_trap", 32'(obs()), 32'(TRAP_EXP));
        check("mem_err_cause", 32'(trap_cause), 32'(exp_cause));

        // --- FETCH never acked: BUS_TIMEOUT=4 wait cycles, then trap ---
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            #1;
            check("timeout_wait", 32'({bus_req, trap}), 32'b10);
        end
        @(negedge clk);
        #1;
        exp_cause = 2'd3;
        $display("trap timeout: trap=%0d cause=%0d pc_sel=%0d", trap, trap_cause, pc_sel);
        check("timeout_trap", 32'(obs()), 32'(TRAP_EXP));
        check("timeout_cause", 32'(trap_cause), 32'(exp_cause));

        // --- Recovery: a normal instruction retires and cause is held ---
        run_vec(tbl[1]);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
